inst_mem_responder: RTL and testbench
=====================================

# inst_mem_responder

Responder side of the core's instruction-fetch port: accepts the fetch stage's `INST_RDEN`/`INST_RIADDR` requests and drives `STALL` back to it. Translates each accepted request into a single-outstanding read on the instruction memory bus, then returns the data, the echoed address and an error flag to the decode stage. Sits between the fetch stage and the instruction memory/bus bridge. Also supports pipeline flush, misaligned-address faults and a memory timeout.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles spent in WAIT before an error is reported; range 1..65535.
- `CLK`  in  1  clock.
- `RST`  in  1  reset, asynchronous, active-high.
- `INST_RDEN`  in  1  fetch request valid.
- `INST_RIADDR`  in  32  fetch byte address.
- `STALL`  out  1  back-pressure to fetch; fetch holds its request while high.
- `FLUSH`  in  1  discard any in-flight or just-presented request (branch/trap).
- `MEM_RDEN`  out  1  memory read strobe, one-cycle pulse.
- `MEM_RADDR`  out  32  memory word address (byte address, `[1:0]`=0).
- `MEM_RVALID`  in  1  memory read data valid.
- `MEM_RDATA`  in  32  memory read data.
- `MEM_RERR`  in  1  memory error, qualified by `MEM_RVALID`.
- `INST_RVALID`  out  1  instruction response valid, one-cycle pulse.
- `INST_RADDR`  out  32  address of the returned instruction.
- `INST_RDATA`  out  32  returned instruction; 0 when `INST_RERR`=1.
- `INST_RERR`  out  1  fault: misaligned, memory error or timeout.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- Accept condition: in IDLE or RESP, `INST_RDEN`=1, `FLUSH`=0. `STALL` is 0 in these states.
- Aligned accept (`INST_RIADDR[1:0]`=0): latch the address and go to REQ.
- Misaligned accept: go straight to RESP with `INST_RERR`=1 and data 0. No memory access is issued.
- REQ: `MEM_RDEN`=1, `MEM_RADDR`=latched address. Then go to WAIT; the timeout counter clears.
- WAIT: when `MEM_RVALID`=1, capture `MEM_RDATA`/`MEM_RERR` and go to RESP.
  - Otherwise the counter increments.
  - When the counter reaches `TIMEOUT_CYCLES`, go to RESP with error. Any later stray `MEM_RVALID` is ignored.
- RESP: `INST_RVALID`=1 unless the drop flag is set.
  - Then accept a new request (go to REQ, or to RESP if misaligned) or go to IDLE.
- `STALL` = state is REQ or WAIT. It is decoded from the state register only; there is no combinational path from inputs.
- FLUSH rules:
  - In REQ or WAIT: set the drop flag. The memory read still completes (single outstanding), and the response is suppressed.
  - In IDLE or RESP: blocks acceptance that cycle. In RESP it also suppresses that cycle's `INST_RVALID`.
  - The drop flag clears on leaving RESP.
- Reset values: state IDLE, `STALL`=0, `MEM_RDEN`=0, `MEM_RADDR`=0, `INST_RVALID`=0, `INST_RADDR`=0, `INST_RDATA`=0, `INST_RERR`=0, drop flag 0, counter 0.
- Reset asserted mid-transaction abandons the transaction. Any `MEM_RVALID` arriving after reset deasserts while in IDLE is ignored.

## Timing
- Edge 0: request accepted.
- Cycle 1: REQ; `MEM_RDEN`=1 and `STALL`=1.
- Cycle 2 onward: WAIT. The earliest `MEM_RVALID` that is honoured is sampled at the end of cycle 2.
- The cycle after `MEM_RVALID`: RESP, with `INST_RVALID`, `INST_RADDR`, `INST_RDATA` and `INST_RERR` registered and `STALL`=0.
- Latency from accept to `INST_RVALID` = memory latency + 2 cycles. Back-to-back throughput = one instruction per (memory latency + 2) cycles.
- Misaligned request: `INST_RVALID` in the cycle after accept; `STALL` stays 0.
- Timeout: RESP is entered on the cycle after the counter equals `TIMEOUT_CYCLES`.
- Outputs are held stable in every cycle where `INST_RVALID`=0.

## Structure
- Shared package `inst_mem_pkg`:
  - state encoding constants (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, RESP=2'd3);
  - `INST_NOP_DATA`=32'h0000_0000 for faulted responses.
- One natural sub-module: `inst_mem_timeout`, the loadable/clearable counter with a terminal-count flag. Everything else is a single FSM in `inst_mem_responder`.

## Test plan
- Single fetch: `INST_RIADDR`=0x0000_0000, memory returns 0x0000_0013 two cycles after `MEM_RDEN` -> `MEM_RADDR`=0; `INST_RVALID` 4 cycles after accept with data 0x13, addr 0, `INST_RERR`=0; `STALL` high for exactly 3 cycles.
- Streaming with the fetch model incrementing by 4 and a 1-cycle memory -> addresses 0x0, 0x4, 0x8, 0xC returned in order, one every 3 cycles, none skipped or duplicated.
- Misaligned `INST_RIADDR`=0x0000_0002 -> no `MEM_RDEN`; next cycle `INST_RVALID`=1, `INST_RERR`=1, data 0.
- FLUSH asserted in WAIT, memory returns 0xDEADBEEF -> no `INST_RVALID`; the next request is accepted in RESP and returned normally.
- `TIMEOUT_CYCLES`=4, memory silent -> `INST_RVALID` with `INST_RERR`=1 and data 0 after the timeout; a late `MEM_RVALID` is ignored. A separate run with `MEM_RERR`=1 -> `INST_RERR`=1.
- `RST` pulsed while in WAIT -> all outputs return to reset values immediately; no response is emitted and the subsequent fetch completes normally.

Source files
------------

// File: rtl/inst_mem_pkg.sv
// Shared definitions for the instruction-fetch responder: FSM encoding,
// the faulted-response filler word and the alignment helper.
package inst_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [31:0] INST_NOP_DATA = 32'h0000_0000;

    // Timeout counter width covers the full TIMEOUT_CYCLES range of 1..65535.
    localparam int TO_W = 16;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/inst_mem_responder_if.sv
// Fetch-side request/response and instruction-memory read bus seen by the
// responder; the slave modport is the responder's view.
interface inst_mem_responder_if;

    logic        INST_RDEN;
    logic [31:0] INST_RIADDR;
    logic        STALL;
    logic        FLUSH;

    logic        MEM_RDEN;
    logic [31:0] MEM_RADDR;
    logic        MEM_RVALID;
    logic [31:0] MEM_RDATA;
    logic        MEM_RERR;

    logic        INST_RVALID;
    logic [31:0] INST_RADDR;
    logic [31:0] INST_RDATA;
    logic        INST_RERR;

    modport slave (
        input  INST_RDEN, INST_RIADDR, FLUSH, MEM_RVALID, MEM_RDATA, MEM_RERR,
        output STALL, MEM_RDEN, MEM_RADDR, INST_RVALID, INST_RADDR, INST_RDATA, INST_RERR
    );

    modport master (
        output INST_RDEN, INST_RIADDR, FLUSH, MEM_RVALID, MEM_RDATA, MEM_RERR,
        input  STALL, MEM_RDEN, MEM_RADDR, INST_RVALID, INST_RADDR, INST_RDATA, INST_RERR
    );

endinterface

// File: rtl/inst_mem_timeout.sv
// Clearable wait-cycle counter; tc rises when the count reaches TIMEOUT_CYCLES
// and the count then holds there until cleared.
module inst_mem_timeout
    import inst_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == TO_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/inst_mem_responder.sv
// Fetch-port responder: turns accepted fetch requests into single-outstanding
// instruction-memory reads and returns data/address/error to decode.
module inst_mem_responder
    import inst_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                 CLK,
    input logic                 RST,
    inst_mem_responder_if.slave bus
);

    state_t      state;
    logic        drop;
    logic        resp_vld;
    logic        mem_rden;
    logic [31:0] mem_raddr;
    logic [31:0] inst_raddr;
    logic [31:0] inst_rdata;
    logic        inst_rerr;

    logic accept;
    logic to_clr;
    logic to_inc;
    logic to_tc;

    assign accept = ((state == IDLE) || (state == RESP)) && bus.INST_RDEN && !bus.FLUSH;
    assign to_clr = (state == REQ);
    assign to_inc = (state == WAIT) && !bus.MEM_RVALID;

    inst_mem_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .CLK (CLK),
        .RST (RST),
        .clr (to_clr),
        .inc (to_inc),
        .tc  (to_tc)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            drop       <= 1'b0;
            resp_vld   <= 1'b0;
            mem_rden   <= 1'b0;
            mem_raddr  <= '0;
            inst_raddr <= '0;
            inst_rdata <= '0;
            inst_rerr  <= 1'b0;
        end else begin
            mem_rden <= 1'b0;
            resp_vld <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    drop <= 1'b0;
                    if (accept) begin
                        if (is_misaligned(bus.INST_RIADDR)) begin
                            state      <= RESP;
                            resp_vld   <= 1'b1;
                            inst_raddr <= bus.INST_RIADDR;
                            inst_rdata <= INST_NOP_DATA;
                            inst_rerr  <= 1'b1;
                        end else begin
                            state     <= REQ;
                            mem_rden  <= 1'b1;
                            mem_raddr <= bus.INST_RIADDR;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                REQ: begin
                    if (bus.FLUSH) drop <= 1'b1;
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.FLUSH) drop <= 1'b1;
                    // Memory data wins over a timeout landing in the same cycle.
                    if (bus.MEM_RVALID || to_tc) begin
                        state <= RESP;
                        if (!(drop || bus.FLUSH)) begin
                            resp_vld   <= 1'b1;
                            inst_raddr <= mem_raddr;
                            inst_rdata <= (bus.MEM_RVALID && !bus.MEM_RERR) ? bus.MEM_RDATA
                                                                             : INST_NOP_DATA;
                            inst_rerr  <= !bus.MEM_RVALID || bus.MEM_RERR;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.STALL       = (state == REQ) || (state == WAIT);
    assign bus.MEM_RDEN    = mem_rden;
    assign bus.MEM_RADDR   = mem_raddr;
    // A flush presented during RESP still cancels the response going out that cycle.
    assign bus.INST_RVALID = resp_vld && !bus.FLUSH;
    assign bus.INST_RADDR  = inst_raddr;
    assign bus.INST_RDATA  = inst_rdata;
    assign bus.INST_RERR   = inst_rerr;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Scoreboard bench for inst_mem_responder: fetch driver, latency-programmable
// memory model, and a monitor that pops expected responses as they appear.
`timescale 1ns/1ps
module tb_inst_mem_responder;
    import inst_mem_pkg::*;

    localparam int unsigned TO = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    inst_mem_responder_if bus();

    inst_mem_responder #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        int          lat;
        int          acc;
        int          gap;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] raddr_q[$];
    exp_t        e;

    int n_checks  = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int stall_cnt = 0;
    int rden_cnt  = 0;
    int resp_cnt  = 0;
    int last_resp = 0;
    int r0        = 0;

    int          mem_lat  = 2;
    bit          mem_err  = 1'b0;
    int          mem_cnt  = -1;
    logic [31:0] mem_addr = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEAD_BEEF;
        return 32'h13 + (a << 8);
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_stall"},       bus.STALL,       0);
        check({tag, "_mem_rden"},    bus.MEM_RDEN,    0);
        check({tag, "_mem_raddr"},   bus.MEM_RADDR,   0);
        check({tag, "_inst_rvalid"}, bus.INST_RVALID, 0);
        check({tag, "_inst_raddr"},  bus.INST_RADDR,  0);
        check({tag, "_inst_rdata"},  bus.INST_RDATA,  0);
        check({tag, "_inst_rerr"},   bus.INST_RERR,   0);
    endtask

    // Present a request and hold it until accepted; returns one tick after the accept edge.
    task automatic issue(input logic [31:0] a, input bit push, input logic [31:0] d,
                         input logic er, input int lat, input int gap);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        bus.INST_RDEN   = 1'b1;
        bus.INST_RIADDR = a;
        while (!ok && n < 64) begin
            @(negedge CLK);
            ok = !bus.STALL && !bus.FLUSH;
            @(posedge CLK);
            #1;
            n++;
        end
        if (!ok) begin
            check("accept_bound", {63'd0, ok}, 1);
            return;
        end
        if (a[1:0] == 2'b00) raddr_q.push_back(a);
        if (push) exp_q.push_back('{a, d, er, lat, cyc - 1, gap});
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Memory model: answers MEM_RDEN after mem_lat cycles, one read outstanding.
    initial begin
        bus.MEM_RVALID = 1'b0;
        bus.MEM_RDATA  = '0;
        bus.MEM_RERR   = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            bus.MEM_RVALID = 1'b0;
            bus.MEM_RERR   = 1'b0;
            if (mem_cnt == 0) begin
                bus.MEM_RVALID = 1'b1;
                bus.MEM_RDATA  = mem_word(mem_addr);
                bus.MEM_RERR   = mem_err;
            end
            if (mem_cnt >= 0) mem_cnt--;
            if (bus.MEM_RDEN) begin
                mem_addr = bus.MEM_RADDR;
                mem_cnt  = mem_lat - 1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (bus.STALL) stall_cnt++;
            if (bus.MEM_RDEN) begin
                rden_cnt++;
                if (raddr_q.size() == 0) check("unexpected_mem_rden", bus.MEM_RDEN, 0);
                else check("mem_raddr", bus.MEM_RADDR, raddr_q.pop_front());
            end
            if (bus.INST_RVALID) begin
                resp_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_inst_rvalid", bus.INST_RVALID, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("inst_raddr", bus.INST_RADDR, e.addr);
                    check("inst_rdata", bus.INST_RDATA, e.data);
                    check("inst_rerr",  bus.INST_RERR,  e.err);
                    check("latency",    cyc - e.acc,    e.lat);
                    if (e.gap >= 0) check("resp_gap", cyc - last_resp, e.gap);
                end
                last_resp = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.INST_RDEN   = 1'b0;
        bus.INST_RIADDR = '0;
        bus.FLUSH       = 1'b0;
        RST             = 1'b1;
        repeat (2) @(negedge CLK);
        check_reset("por");
        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        // Single fetch, memory latency 2
        mem_lat   = 2;
        stall_cnt = 0;
        rden_cnt  = 0;
        issue(32'h0, 1'b1, 32'h13, 1'b0, 4, -1);
        bus.INST_RDEN = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        check("single_stall_cycles", stall_cnt, 3);
        check("single_rden_pulses",  rden_cnt,  1);

        // Streaming, memory latency 1
        mem_lat = 1;
        r0      = resp_cnt;
        for (int i = 0; i < 4; i++)
            issue(32'(i * 4), 1'b1, mem_word(32'(i * 4)), 1'b0, 3, (i == 0) ? -1 : 3);
        bus.INST_RDEN = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        check("stream_resp_count", resp_cnt - r0, 4);

        // Misaligned request
        rden_cnt  = 0;
        stall_cnt = 0;
        issue(32'h2, 1'b1, 32'h0, 1'b1, 1, -1);
        bus.INST_RDEN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("misaligned_rden_pulses", rden_cnt,  0);
        check("misaligned_stall_cycles", stall_cnt, 0);

        // Flush during WAIT, then next request accepted in RESP
        mem_lat = 2;
        issue(32'h40, 1'b0, 32'h0, 1'b0, 0, -1);
        bus.INST_RDEN = 1'b0;
        @(posedge CLK);
        #1;
        bus.FLUSH = 1'b1;
        @(posedge CLK);
        #1;
        bus.FLUSH = 1'b0;
        r0 = resp_cnt;
        issue(32'h44, 1'b1, mem_word(32'h44), 1'b0, 4, -1);
        bus.INST_RDEN = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        check("flush_resp_count", resp_cnt - r0, 1);

        // Timeout with silent memory; its late answer lands while idle
        mem_lat = 8;
        r0      = resp_cnt;
        issue(32'h80, 1'b1, 32'h0, 1'b1, TO + 3, -1);
        bus.INST_RDEN = 1'b0;
        repeat (14) @(posedge CLK);
        #1;
        check("timeout_resp_count", resp_cnt - r0, 1);

        // Memory error
        mem_lat = 1;
        mem_err = 1'b1;
        issue(32'h90, 1'b1, 32'h0, 1'b1, 3, -1);
        bus.INST_RDEN = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        mem_err = 1'b0;

        // Reset while waiting on memory
        mem_lat = 2;
        issue(32'hA0, 1'b0, 32'h0, 1'b0, 0, -1);
        bus.INST_RDEN = 1'b0;
        @(posedge CLK);
        #1;
        check("rst_pre_stall", bus.STALL, 1);
        #2;
        RST = 1'b1;
        #1;
        check_reset("mid_rst");
        @(posedge CLK);
        #1;
        RST = 1'b0;
        r0  = resp_cnt;
        repeat (4) @(posedge CLK);
        #1;
        check("rst_no_resp", resp_cnt - r0, 0);
        issue(32'hA4, 1'b1, mem_word(32'hA4), 1'b0, 4, -1);
        bus.INST_RDEN = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        check("rst_after_resp_count", resp_cnt - r0, 1);

        check("exp_q_drained",   exp_q.size(),   0);
        check("raddr_q_drained", raddr_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
